// File: rtl/prog_mem_controller_if.sv
// Fetcher-side and memory-side read buses of the program-memory arbiter.
// The controller connects through slave; the fetchers and memory model drive master.
interface prog_mem_controller_if #(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned NUM_CHANNELS  = 1
);
  logic [NUM_CONSUMERS-1:0]            consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0] consumer_read_addr;
  logic [NUM_CONSUMERS-1:0]            consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_WIDTH-1:0] consumer_read_data;
  logic [NUM_CHANNELS-1:0]             mem_read_valid;
  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]  mem_read_addr;
  logic [NUM_CHANNELS-1:0]             mem_read_ready;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  mem_read_data;

  modport master (
    output consumer_read_valid, consumer_read_addr, mem_read_ready, mem_read_data,
    input  consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_addr
  );

  modport slave (
    input  consumer_read_valid, consumer_read_addr, mem_read_ready, mem_read_data,
    output consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_addr
  );
endinterface

// File: rtl/prog_mem_controller.sv
// Round-robin arbiter relaying instruction fetches from NUM_CONSUMERS fetchers
// onto NUM_CHANNELS independent read channels of the program memory.
module prog_mem_controller #(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned NUM_CHANNELS  = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  prog_mem_controller_if.slave bus
);
  localparam int unsigned PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  localparam logic [1:0] CH_IDLE     = 2'd0;
  localparam logic [1:0] CH_WAITING  = 2'd1;
  localparam logic [1:0] CH_RELAYING = 2'd2;

  logic [1:0]                          state_q [NUM_CHANNELS];
  logic [1:0]                          state_d [NUM_CHANNELS];
  logic [PTR_W-1:0]                    owner_q [NUM_CHANNELS];
  logic [PTR_W-1:0]                    owner_d [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]            claimed_q, claimed_d;
  logic [PTR_W-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [NUM_CHANNELS-1:0]             mem_valid_q, mem_valid_d;
  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [NUM_CONSUMERS-1:0]            cons_ready_q, cons_ready_d;
  logic [NUM_CONSUMERS*DATA_WIDTH-1:0] cons_data_q, cons_data_d;

  logic [NUM_CONSUMERS-1:0] avail;
  logic                     found;
  logic [PTR_W-1:0]         sel;
  logic [PTR_W-1:0]         cand_idx;
  int unsigned              cand;

  // Channels evaluated in ascending order; avail shrinks as lower channels grant.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    claimed_d    = claimed_q;
    rr_ptr_d     = rr_ptr_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    cons_ready_d = cons_ready_q;
    cons_data_d  = cons_data_q;
    avail        = bus.consumer_read_valid & ~claimed_q;
    found        = 1'b0;
    sel          = '0;
    cand_idx     = '0;
    cand         = 0;

    for (int ch = 0; ch < int'(NUM_CHANNELS); ch++) begin
      case (state_q[ch])
        CH_IDLE: begin
          found = 1'b0;
          sel   = '0;
          for (int k = 0; k < int'(NUM_CONSUMERS); k++) begin
            cand = 32'(rr_ptr_q) + 32'(k);
            if (cand >= NUM_CONSUMERS) cand = cand - NUM_CONSUMERS;
            cand_idx = PTR_W'(cand);
            if (!found && avail[cand_idx]) begin
              found = 1'b1;
              sel   = cand_idx;
            end
          end
          if (found) begin
            owner_d[ch]     = sel;
            claimed_d[sel]  = 1'b1;
            avail[sel]      = 1'b0;
            mem_valid_d[ch] = 1'b1;
            state_d[ch]     = CH_WAITING;
            mem_addr_d[ch*ADDR_WIDTH +: ADDR_WIDTH] =
              bus.consumer_read_addr[32'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
            // Later (higher) channels overwrite, so the highest grant sets the pointer.
            rr_ptr_d = (32'(sel) + 32'd1 >= NUM_CONSUMERS) ? '0 : PTR_W'(32'(sel) + 32'd1);
          end
        end
        CH_WAITING: begin
          if (bus.mem_read_ready[ch]) begin
            mem_valid_d[ch]              = 1'b0;
            cons_ready_d[owner_q[ch]]    = 1'b1;
            state_d[ch]                  = CH_RELAYING;
            cons_data_d[32'(owner_q[ch])*DATA_WIDTH +: DATA_WIDTH] =
              bus.mem_read_data[ch*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        CH_RELAYING: begin
          if (!bus.consumer_read_valid[owner_q[ch]]) begin
            cons_ready_d[owner_q[ch]] = 1'b0;
            claimed_d[owner_q[ch]]    = 1'b0;
            state_d[ch]               = CH_IDLE;
          end
        end
        default: state_d[ch] = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int ch = 0; ch < int'(NUM_CHANNELS); ch++) begin
        state_q[ch] <= CH_IDLE;
        owner_q[ch] <= '0;
      end
      claimed_q    <= '0;
      rr_ptr_q     <= '0;
      mem_valid_q  <= '0;
      mem_addr_q   <= '0;
      cons_ready_q <= '0;
      cons_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      claimed_q    <= claimed_d;
      rr_ptr_q     <= rr_ptr_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      cons_ready_q <= cons_ready_d;
      cons_data_q  <= cons_data_d;
    end
  end

  assign bus.mem_read_valid      = mem_valid_q;
  assign bus.mem_read_addr       = mem_addr_q;
  assign bus.consumer_read_ready = cons_ready_q;
  assign bus.consumer_read_data  = cons_data_q;
endmodule

// File: tb/tb_prog_mem_controller.sv
// Directed bench: one-channel and two-channel arbiters, vector table plus
// hand-written multi-cycle sequences.
module tb_prog_mem_controller;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  prog_mem_controller_if #(.NUM_CHANNELS(1)) bus1 ();
  prog_mem_controller_if #(.NUM_CHANNELS(2)) bus2 ();

  prog_mem_controller #(.NUM_CHANNELS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  prog_mem_controller #(.NUM_CHANNELS(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] addr;
    logic        mready;
    logic [15:0] mdata;
    logic        evalid;
    logic [7:0]  eaddr;
    logic [3:0]  eready;
    logic [63:0] edata;
  } vec_t;

  localparam logic [31:0] A  = 32'h441A_2211;
  localparam logic [31:0] A2 = 32'h44FF_2211;
  localparam logic [63:0] D0 = 64'h0;
  localparam logic [63:0] D1 = 64'h0000_BEEF_0000_0000;
  localparam logic [63:0] D2 = 64'hA5A5_BEEF_0000_0000;
  localparam logic [63:0] D3 = 64'hA5A5_BEEF_0000_0F0F;
  localparam logic [63:0] D4 = 64'hA5A5_BEEF_7777_0F0F;
  localparam logic [63:0] D5 = 64'hA5A5_1111_7777_0F0F;

  vec_t       vecs [19];
  logic [7:0] rr_addr [4];
  logic [3:0] exp_rdy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    bus1.consumer_read_valid = '0; bus1.consumer_read_addr = A;
    bus1.mem_read_ready = '0;      bus1.mem_read_data = '0;
    bus2.consumer_read_valid = '0; bus2.consumer_read_addr = A;
    bus2.mem_read_ready = '0;      bus2.mem_read_data = '0;

    // inputs, then outputs expected right after the edge that samples them
    vecs[0]  = '{4'b0100, A,  1'b0, 16'h0000, 1'b1, 8'h1A, 4'b0000, D0};
    vecs[1]  = '{4'b0100, A,  1'b1, 16'hBEEF, 1'b0, 8'h1A, 4'b0100, D1};
    vecs[2]  = '{4'b0100, A,  1'b0, 16'h0000, 1'b0, 8'h1A, 4'b0100, D1};
    vecs[3]  = '{4'b0000, A,  1'b0, 16'h0000, 1'b0, 8'h1A, 4'b0000, D1};
    vecs[4]  = '{4'b0000, A,  1'b1, 16'h1234, 1'b0, 8'h1A, 4'b0000, D1};
    vecs[5]  = '{4'b1001, A,  1'b0, 16'h0000, 1'b1, 8'h44, 4'b0000, D1};
    vecs[6]  = '{4'b1001, A,  1'b1, 16'hA5A5, 1'b0, 8'h44, 4'b1000, D2};
    vecs[7]  = '{4'b0001, A,  1'b0, 16'h0000, 1'b0, 8'h44, 4'b0000, D2};
    vecs[8]  = '{4'b0001, A,  1'b0, 16'h0000, 1'b1, 8'h11, 4'b0000, D2};
    vecs[9]  = '{4'b0001, A,  1'b1, 16'h0F0F, 1'b0, 8'h11, 4'b0001, D3};
    vecs[10] = '{4'b0000, A,  1'b1, 16'hFFFF, 1'b0, 8'h11, 4'b0000, D3};
    vecs[11] = '{4'b0010, A,  1'b0, 16'h0000, 1'b1, 8'h22, 4'b0000, D3};
    vecs[12] = '{4'b0000, A,  1'b0, 16'h0000, 1'b1, 8'h22, 4'b0000, D3};
    vecs[13] = '{4'b0000, A,  1'b1, 16'h7777, 1'b0, 8'h22, 4'b0010, D4};
    vecs[14] = '{4'b0000, A,  1'b0, 16'h0000, 1'b0, 8'h22, 4'b0000, D4};
    vecs[15] = '{4'b0100, A,  1'b0, 16'h0000, 1'b1, 8'h1A, 4'b0000, D4};
    vecs[16] = '{4'b0100, A2, 1'b0, 16'h0000, 1'b1, 8'h1A, 4'b0000, D4};
    vecs[17] = '{4'b0100, A,  1'b1, 16'h1111, 1'b0, 8'h1A, 4'b0100, D5};
    vecs[18] = '{4'b0000, A,  1'b0, 16'h0000, 1'b0, 8'h1A, 4'b0000, D5};
    rr_addr = '{8'h11, 8'h22, 8'h1A, 8'h44};

    do_reset();
    check("rst_mvalid", 64'(bus1.mem_read_valid), 64'd0);
    check("rst_maddr",  64'(bus1.mem_read_addr), 64'd0);
    check("rst_cready", 64'(bus1.consumer_read_ready), 64'd0);
    check("rst_cdata",  bus1.consumer_read_data, 64'd0);
    check("rst_mvalid2", 64'(bus2.mem_read_valid), 64'd0);

    for (int i = 0; i < 19; i++) begin
      bus1.consumer_read_valid = vecs[i].valid;
      bus1.consumer_read_addr  = vecs[i].addr;
      bus1.mem_read_ready      = vecs[i].mready;
      bus1.mem_read_data       = vecs[i].mdata;
      tick();
      check($sformatf("v%0d_mvalid", i), 64'(bus1.mem_read_valid), 64'(vecs[i].evalid));
      check($sformatf("v%0d_maddr", i),  64'(bus1.mem_read_addr), 64'(vecs[i].eaddr));
      check($sformatf("v%0d_cready", i), 64'(bus1.consumer_read_ready), 64'(vecs[i].eready));
      check($sformatf("v%0d_cdata", i),  bus1.consumer_read_data, vecs[i].edata);
    end

    // Reset while a fetch is waiting on memory
    bus1.mem_read_ready = 1'b0;
    bus1.consumer_read_valid = 4'b0100;
    tick();
    check("midrst_wait", 64'(bus1.mem_read_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_mvalid", 64'(bus1.mem_read_valid), 64'd0);
    check("midrst_maddr",  64'(bus1.mem_read_addr), 64'd0);
    check("midrst_cready", 64'(bus1.consumer_read_ready), 64'd0);
    check("midrst_cdata",  bus1.consumer_read_data, 64'd0);
    bus1.consumer_read_valid = 4'b1010;
    tick();
    check("midrst_grant_from0", 64'(bus1.mem_read_addr), 64'h22);
    bus1.mem_read_ready = 1'b1;
    bus1.mem_read_data  = 16'h5A5A;
    tick();
    check("midrst_ready", 64'(bus1.consumer_read_ready), 64'b0010);
    bus1.mem_read_ready = 1'b0;
    bus1.consumer_read_valid = 4'b0000;
    tick();

    // Round robin, every fetcher requesting
    do_reset();
    bus1.consumer_read_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rr%0d_addr", i), 64'(bus1.mem_read_addr), 64'(rr_addr[i % 4]));
      check($sformatf("rr%0d_mvalid", i), 64'(bus1.mem_read_valid), 64'd1);
      bus1.mem_read_ready = 1'b1;
      bus1.mem_read_data  = 16'(i);
      tick();
      exp_rdy = 4'b0001 << (i % 4);
      check($sformatf("rr%0d_ready", i), 64'(bus1.consumer_read_ready), 64'(exp_rdy));
      bus1.mem_read_ready = 1'b0;
      bus1.consumer_read_valid[i % 4] = 1'b0;
      tick();
      check($sformatf("rr%0d_release", i), 64'(bus1.consumer_read_ready), 64'd0);
      bus1.consumer_read_valid = (i == 4) ? 4'b0000 : 4'b1111;
    end

    // Memory stall of 10 cycles
    bus1.consumer_read_valid = 4'b0001;
    tick();
    check("stall_grant", 64'(bus1.mem_read_addr), 64'h11);
    for (int i = 0; i < 10; i++) begin
      bus1.consumer_read_addr = 32'hFFFF_FFFF;
      tick();
      check("stall_mvalid", 64'(bus1.mem_read_valid), 64'd1);
      check("stall_maddr",  64'(bus1.mem_read_addr), 64'h11);
      check("stall_cready", 64'(bus1.consumer_read_ready), 64'd0);
    end
    bus1.mem_read_ready = 1'b1;
    bus1.mem_read_data  = 16'hC0DE;
    tick();
    check("stall_ready",  64'(bus1.consumer_read_ready), 64'b0001);
    check("stall_mdrop",  64'(bus1.mem_read_valid), 64'd0);
    check("stall_data",   64'(bus1.consumer_read_data[15:0]), 64'hC0DE);
    bus1.mem_read_ready = 1'b0;
    bus1.consumer_read_valid = 4'b0000;
    tick();
    check("stall_release", 64'(bus1.consumer_read_ready), 64'd0);

    // Two channels
    do_reset();
    bus2.consumer_read_valid = 4'b1010;
    tick();
    check("ch2_mvalid", 64'(bus2.mem_read_valid), 64'b11);
    check("ch2_maddr",  64'(bus2.mem_read_addr), 64'h4422);
    bus2.mem_read_ready = 2'b11;
    bus2.mem_read_data  = 32'hBBBB_AAAA;
    tick();
    check("ch2_cready", 64'(bus2.consumer_read_ready), 64'b1010);
    check("ch2_cdata",  bus2.consumer_read_data, 64'hBBBB_0000_AAAA_0000);
    check("ch2_mdrop",  64'(bus2.mem_read_valid), 64'b00);
    bus2.mem_read_ready = 2'b00;
    bus2.consumer_read_valid = 4'b0000;
    tick();
    check("ch2_release", 64'(bus2.consumer_read_ready), 64'd0);
    bus2.consumer_read_valid = 4'b1001;
    tick();
    check("ch2_rr0_mvalid", 64'(bus2.mem_read_valid), 64'b11);
    check("ch2_rr0_maddr",  64'(bus2.mem_read_addr), 64'h4411);
    bus2.mem_read_ready = 2'b01;
    bus2.mem_read_data  = 32'h0002_0001;
    tick();
    check("ch2_part_cready", 64'(bus2.consumer_read_ready), 64'b0001);
    check("ch2_part_mvalid", 64'(bus2.mem_read_valid), 64'b10);
    bus2.mem_read_ready = 2'b10;
    bus2.consumer_read_valid = 4'b1000;
    tick();
    check("ch2_swap_cready", 64'(bus2.consumer_read_ready), 64'b1000);
    check("ch2_swap_mvalid", 64'(bus2.mem_read_valid), 64'b00);
    check("ch2_swap_cdata",  bus2.consumer_read_data, 64'h0002_0000_AAAA_0001);
    bus2.mem_read_ready = 2'b00;
    bus2.consumer_read_valid = 4'b0000;
    tick();
    bus2.consumer_read_valid = 4'b0100;
    tick();
    check("ch2_single_mvalid", 64'(bus2.mem_read_valid), 64'b01);
    check("ch2_single_maddr",  64'(bus2.mem_read_addr), 64'h441A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/prog_mem_controller.md
# prog_mem_controller

Program-memory read arbiter between the per-core instruction fetchers and the external program memory. It accepts up to NUM_CONSUMERS concurrent fetch requests (valid/addr held until ready) and multiplexes them onto NUM_CHANNELS independent memory read channels. Round-robin arbitration guarantees every fetcher is served. Each granted request is relayed back with its instruction word. Read-only: program memory is never written.

## Interface
Parameters:
- ADDR_WIDTH, 8, program memory address width
- DATA_WIDTH, 16, instruction width
- NUM_CONSUMERS, 4, number of fetchers served (≥1)
- NUM_CHANNELS, 1, number of memory read channels (1 ≤ NUM_CHANNELS ≤ NUM_CONSUMERS)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- consumer_read_valid  in  NUM_CONSUMERS  per-fetcher request, held until served
- consumer_read_addr  in  NUM_CONSUMERS*ADDR_WIDTH  packed addresses, consumer i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- consumer_read_ready  out  NUM_CONSUMERS  per-fetcher response strobe
- consumer_read_data  out  NUM_CONSUMERS*DATA_WIDTH  packed instruction words
- mem_read_valid  out  NUM_CHANNELS  per-channel memory request
- mem_read_addr  out  NUM_CHANNELS*ADDR_WIDTH  packed channel addresses
- mem_read_ready  in  NUM_CHANNELS  per-channel memory response
- mem_read_data  in  NUM_CHANNELS*DATA_WIDTH  packed channel read data

## Operation
- Per-channel FSM: CH_IDLE → CH_WAITING → CH_RELAYING → CH_IDLE.
- Per-channel registers: owner index, claimed flag. Global: claimed mask [NUM_CONSUMERS], rr_ptr (clog2(NUM_CONSUMERS) bits, min 1).
- CH_IDLE: channel selects the first consumer at or after rr_ptr (modulo NUM_CONSUMERS) with valid=1 and not claimed. Channels are evaluated in ascending index within one cycle. A consumer taken by a lower channel is invisible to higher channels that same cycle. On grant: set owner, set claimed[owner], latch the consumer's address onto mem_read_addr, mem_read_valid←1, go CH_WAITING.
- rr_ptr update: after any grant in a cycle, rr_ptr ← (highest-numbered channel's granted index + 1) mod NUM_CONSUMERS. With no grant, unchanged.
- CH_WAITING: hold mem_read_valid/addr stable. When mem_read_ready=1: mem_read_valid←0, consumer_read_data[owner]←mem_read_data, consumer_read_ready[owner]←1, go CH_RELAYING.
- CH_RELAYING: hold ready/data. When consumer_read_valid[owner]=0: consumer_read_ready[owner]←0, clear claimed[owner], go CH_IDLE. consumer_read_data keeps its last value (not cleared).
- Address is sampled at grant only. Later changes to consumer_read_addr while owned are ignored.
- A consumer that drops valid before it is granted is simply not served. A consumer dropping valid during CH_WAITING is not aborted: the response is still relayed, and the channel returns to CH_IDLE on the first cycle valid is observed low in CH_RELAYING.
- At most one channel owns a given consumer at a time (claimed mask). Any consumer_read_ready bit is driven by at most one channel.

## Timing
- Reset (rst_n=0 at a rising edge): every channel to CH_IDLE, claimed mask 0, rr_ptr 0. All outputs 0: mem_read_valid, mem_read_addr, consumer_read_ready, consumer_read_data.
- Reset mid-transaction abandons it. mem_read_valid drops without ready; memory must tolerate this.
- Latencies, all registered:
  - Request valid sampled at edge N with a free channel → mem_read_valid=1 after edge N.
  - mem_read_ready sampled at edge M → consumer_read_ready=1 and data after edge M, mem_read_valid=0 after edge M.
  - Consumer valid low sampled at edge K → ready=0 after edge K.
  - Channel can grant again at edge K+1.
- Minimum fetch round trip with zero-wait memory (ready on first cycle valid seen): 2 cycles request→ready.
- A fetcher that drops valid one cycle after seeing ready sees ready high for exactly 2 cycles. It must ignore the second cycle; the fetcher does this because it is already in FETCH_DONE.
- mem_read_ready while a channel is CH_IDLE or CH_RELAYING is ignored.

## Test plan
- Reset: assert rst_n=0 during CH_WAITING with mem_read_valid=1 → after that edge all outputs 0. Next request is granted from rr_ptr=0.
- Single fetch, NUM_CHANNELS=1: consumer 2 requests addr 8'h1A. Memory returns 16'hBEEF one cycle after valid. → mem_read_addr=8'h1A, consumer_read_ready[2] rises 2 cycles after request with data 16'hBEEF. Ready drops the cycle after valid is seen low.
- Round-robin, 1 channel, all 4 consumers valid continuously → grant order 0,1,2,3,0. No consumer is granted twice before the others.
- Two channels, consumers 1 and 3 valid in the same cycle, rr_ptr=0 → channel 0 owns 1, channel 1 owns 3. Both mem_read_valid rise the same cycle. rr_ptr becomes 0.
- Memory stall: mem_read_ready low for 10 cycles → mem_read_valid/addr stable throughout. No consumer_read_ready asserts until 1 cycle after ready.
- Consumer drops valid during CH_WAITING → response is still captured. Ready pulses for 1 cycle, then the channel returns to CH_IDLE and serves the next consumer.
